// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the 64-bit RISC-V pipeline, feeding the IF/ID register
// (which samples PC_addr / Instruc on the falling edge of clk). Holds the
// program counter, picks the next PC (reset > branch > stall > PC+4) and
// reads the instruction word combinationally from a word-organised memory.
// A write port lets a loader or testbench fill the memory.
//
// Parameters:
//   MEM_BYTES   instruction memory size in bytes (power of two, >= 8)
//   RESET_PC    PC loaded on reset (4-byte aligned)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   stall          hold the PC (load-use hazard)
//   branch_taken   redirect PC to branch_target; overrides stall
//   branch_target  64-bit redirect address
//   imem_we        instruction memory write enable
//   imem_waddr     byte address of the write, bits [1:0] ignored
//   imem_wdata     instruction word to write
//   PC_addr        current PC
//   Instruc        instruction at PC_addr (NOP if misaligned / out of range)
//   PC_plus4       PC_addr + 4, wrapping modulo 2^64
//   fetch_valid    registered, high from the first edge out of reset
//   misaligned     combinational, PC_addr[1:0] != 0
//   fetch_count    registered count of PC advances, wraps at 2^32
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [63:0] PC_addr,
    output logic [31:0] Instruc,
    output logic [63:0] PC_plus4,
    output logic        fetch_valid,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW    = $clog2(MEM_BYTES);
    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic [31:0]   mem [WORDS];

    logic [63:0]   pc_q;
    logic [63:0]   pc_d;
    logic          advance;
    logic          valid_q;
    logic [31:0]   count_q;

    logic          rd_in_range;
    logic [AW-3:0] rd_idx;
    logic          wr_in_range;
    logic [AW-3:0] wr_idx;

    // Byte-lane bits of the write address carry no information.
    logic          unused_waddr_lsbs;
    assign unused_waddr_lsbs = ^imem_waddr[1:0];

    // ------------------------------------------------------------------
    // Address decode: anything with bits set at or above AW lies beyond
    // the memory, for both the read and the write side.
    // ------------------------------------------------------------------
    assign rd_in_range = ((PC_addr >> AW) == 64'd0);
    assign rd_idx      = PC_addr[AW-1:2];
    assign wr_in_range = ((imem_waddr >> AW) == 64'd0);
    assign wr_idx      = imem_waddr[AW-1:2];

    // ------------------------------------------------------------------
    // Next-PC selection. reset is handled in the register itself so it
    // wins over everything; branch beats stall.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        advance = 1'b0;
        if (branch_taken) begin
            pc_d    = branch_target;
            advance = 1'b1;
        end else if (!stall) begin
            pc_d    = pc_q + 64'd4;
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            if (advance) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory write port. Not reset: contents survive reset,
    // and a write coinciding with reset still lands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (imem_we && wr_in_range) begin
            mem[wr_idx] <= imem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The read is asynchronous so Instruc tracks PC_addr within
    // the same cycle; a same-edge write becomes visible after the edge.
    // ------------------------------------------------------------------
    assign PC_addr     = pc_q;
    assign PC_plus4    = pc_q + 64'd4;
    assign misaligned  = (pc_q[1:0] != 2'b00);
    assign fetch_valid = valid_q;
    assign fetch_count = count_q;

    always_comb begin
        Instruc = NOP;
        if (rd_in_range && !misaligned) begin
            Instruc = mem[rd_idx];
        end
    end

endmodule
